coin_input_conditioner: RTL
===========================

# coin_input_conditioner

Conditions the two raw coin-slot push buttons (nickel, dime) into clean single-cycle `N`/`D` pulses for the vending-machine FSM directly downstream. Each raw input is synchronized, debounced, and edge-detected. A small arbiter then serializes coin events so that at most one pulse is ever asserted per cycle, with a guaranteed idle gap between pulses.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a level change (range 2–65535).
- `HOLDOFF_CYCLES`, 2: minimum idle cycles after any issued pulse (range 1–255).
- `CLK`  in  1  system clock
- `RESET`  in  1  reset, asynchronous, active-high; clock `CLK`
- `N_RAW`  in  1  nickel button, asynchronous, bouncy, active-high
- `D_RAW`  in  1  dime button, asynchronous, bouncy, active-high
- `N`  out  1  one-cycle nickel pulse to the FSM
- `D`  out  1  one-cycle dime pulse to the FSM
- `BUSY`  out  1  high in any state other than IDLE, or while a request is pending
- `OVERRUN`  out  1  sticky; a coin edge was dropped

## Operation
- Per input: 2-flop synchronizer, then debouncer.
  - Debouncer keeps a level `lvl` (reset 0) and a counter `cnt` (reset 0).
  - While the synchronized value ≠ `lvl`: `cnt` increments.
  - When the synchronized value = `lvl`: `cnt` clears.
  - When `cnt` reaches `DEBOUNCE_CYCLES` on an increment: `lvl` flips and `cnt` clears.
- A rising edge of `lvl` sets a one-deep pending flag (`pend_n` / `pend_d`). Falling edges are ignored.
- If a rising edge arrives while its pending flag is already set: the edge is dropped and `OVERRUN` is set. `OVERRUN` clears only on `RESET`.
- Arbiter FSM, one-hot encoded. States:
  - IDLE:
    - If `pend_n`: go to PULSE_N.
    - Else if `pend_d`: go to PULSE_D.
    - Nickel has priority on a simultaneous request.
  - PULSE_N: `N`=1 for exactly one cycle. Clears `pend_n`. Goes to HOLDOFF.
  - PULSE_D: `D`=1 for exactly one cycle. Clears `pend_d`. Goes to HOLDOFF.
  - HOLDOFF:
    - Counts `HOLDOFF_CYCLES` cycles, then goes to IDLE.
    - Pending requests accumulate meanwhile and are served from IDLE.
- A pending flag set in the same cycle it is cleared remains set, counting as the new edge.
- `N` and `D` are registered FSM outputs and are never high together.
- A button held through `RESET` deassertion produces exactly one pulse: `lvl` resets to 0, so the held button is seen as a rising edge.

## Timing
- Reset values:
  - `N`=0, `D`=0, `BUSY`=0, `OVERRUN`=0.
  - FSM=IDLE; all counters, levels and pending flags 0.
- Uncontended latency:
  - Edge k is the first edge sampling `N_RAW`=1 with the input stable thereafter.
  - `lvl` flips at edge k+1+`DEBOUNCE_CYCLES`.
  - FSM enters IDLE→PULSE_N at edge k+2+`DEBOUNCE_CYCLES`.
  - `N` is high for the single cycle following that edge.
- Pulse spacing:
  - Minimum period between consecutive output pulses = 2+`HOLDOFF_CYCLES` cycles: pulse cycle, `HOLDOFF_CYCLES` holdoff cycles, one IDLE cycle.
- Bounce shorter than `DEBOUNCE_CYCLES` consecutive cycles produces no pulse and no `lvl` change.
- Reset mid-pulse or mid-holdoff:
  - Outputs return to 0 immediately (asynchronous).
  - Pending requests are discarded.

## Configuration
- `COIN_COUNT_EN` defined:
  - Adds output ports `N_COUNT[7:0]` and `D_COUNT[7:0]`.
  - These are saturating counts of issued `N`/`D` pulses: reset 0, stick at 255.
  - Each count increments in the cycle after the corresponding pulse.
- `COIN_COUNT_EN` undefined: those ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `vm_pkg` holds:
  - Arbiter state one-hot constants: IDLE, PULSE_N, PULSE_D, HOLDOFF.
  - Default `DEBOUNCE_CYCLES`/`HOLDOFF_CYCLES` values.
  - Coin denominations: 5, 10.
- Sub-module `coin_debounce` (synchronizer + debouncer + rising-edge detect, output `rise`), instantiated twice.
- Arbiter, pending flags, `OVERRUN` and optional counters live in the top module.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `HOLDOFF_CYCLES`=2.
- Clean nickel: `N_RAW` 0→1, held for 20 cycles → exactly one `N` pulse, 6 edges after first high sample; `D` stays 0.
- Bounce: `N_RAW` toggles 1,0,1,0,1 each cycle, then holds 1 → exactly one `N` pulse, 6 edges after the final stable 1; no pulse from the glitches.
- Simultaneous press: `N_RAW`/`D_RAW` rise on the same cycle → `N` pulse, then `D` pulse exactly 4 cycles later; never both high.
- Overrun: three clean nickel presses, each 6 cycles high / 6 cycles low, while `D` is continuously served → `OVERRUN`=1 if any nickel edge hits a set `pend_n`; otherwise 0 with three `N` pulses. Check against a reference model.
- Reset mid-operation: assert `RESET` during HOLDOFF with `pend_d` set → `N`=`D`=`BUSY`=0 immediately; no `D` pulse after release unless `D_RAW` is held.
- With `COIN_COUNT_EN`: 260 nickel presses → `N_COUNT` saturates at 255, `D_COUNT`=0.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: arbiter state encoding, default timing
// parameters and coin denominations.
package vm_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    PULSE_N = 4'b0010,
    PULSE_D = 4'b0100,
    HOLDOFF = 4'b1000
  } arb_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DFLT = 16;
  localparam int unsigned HOLDOFF_CYCLES_DFLT  = 2;

  localparam int unsigned NICKEL_VALUE = 5;
  localparam int unsigned DIME_VALUE   = 10;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchronizer, counting debouncer and rising-edge detect for one coin button.
// rise_o is asserted in the cycle before lvl goes high, so it lands on the same edge as the flip.
module coin_debounce
  import vm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw_i,
  output logic rise_o
);

  logic        sync1_q, sync2_q;
  logic        lvl_q, lvl_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Counter runs only while the input disagrees with the accepted level.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign rise_o = lvl_d & ~lvl_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Turns bouncy nickel/dime buttons into spaced, mutually exclusive one-cycle N/D pulses.
// Define COIN_COUNT_EN to add saturating N_COUNT/D_COUNT pulse counters.
module coin_input_conditioner
  import vm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DFLT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       N_RAW,
  input  logic       D_RAW,
  output logic       N,
  output logic       D,
  output logic       BUSY,
  output logic       OVERRUN
`ifdef COIN_COUNT_EN
  ,
  output logic [7:0] N_COUNT,
  output logic [7:0] D_COUNT
`endif
);

  logic       rise_n, rise_d;
  logic       pend_n_q, pend_n_d;
  logic       pend_d_q, pend_d_d;
  logic       ovr_q, ovr_d;
  logic       clr_n, clr_d;
  logic       n_q, d_q;
  logic [7:0] hold_q;
  arb_state_e state_q;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_n (
    .CLK    (CLK),
    .RESET  (RESET),
    .raw_i  (N_RAW),
    .rise_o (rise_n)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .CLK    (CLK),
    .RESET  (RESET),
    .raw_i  (D_RAW),
    .rise_o (rise_d)
  );

  // A request is consumed as its pulse cycle ends; a new edge on that same edge wins.
  assign clr_n    = (state_q == PULSE_N);
  assign clr_d    = (state_q == PULSE_D);
  assign pend_n_d = rise_n | (pend_n_q & ~clr_n);
  assign pend_d_d = rise_d | (pend_d_q & ~clr_d);
  assign ovr_d    = ovr_q | (rise_n & pend_n_q & ~clr_n) | (rise_d & pend_d_q & ~clr_d);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_n_q <= 1'b0;
      pend_d_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      pend_n_q <= pend_n_d;
      pend_d_q <= pend_d_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      hold_q  <= '0;
      n_q     <= 1'b0;
      d_q     <= 1'b0;
    end else begin
      n_q <= 1'b0;
      d_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pend_n_q) begin
            state_q <= PULSE_N;
            n_q     <= 1'b1;
          end else if (pend_d_q) begin
            state_q <= PULSE_D;
            d_q     <= 1'b1;
          end
        end
        PULSE_N, PULSE_D: begin
          state_q <= HOLDOFF;
          hold_q  <= '0;
        end
        HOLDOFF: begin
          if (hold_q == 8'(HOLDOFF_CYCLES - 1)) begin
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign N       = n_q;
  assign D       = d_q;
  assign OVERRUN = ovr_q;
  assign BUSY    = (state_q != IDLE) | pend_n_q | pend_d_q;

`ifdef COIN_COUNT_EN
  logic [7:0] n_cnt_q, d_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      n_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      if (n_q && (n_cnt_q != 8'hFF)) n_cnt_q <= n_cnt_q + 8'd1;
      if (d_q && (d_cnt_q != 8'hFF)) d_cnt_q <= d_cnt_q + 8'd1;
    end
  end

  assign N_COUNT = n_cnt_q;
  assign D_COUNT = d_cnt_q;
`endif

endmodule
